// File: rtl/keccak_dom_pkg.sv
// Shared constants and types for the two-share DOM Keccak-f[800] datapath.
// Reused by the mask loader, the chi S-box and the unmask stage.
package keccak_dom_pkg;

    localparam int KECCAK_W    = 32;
    localparam int KECCAK_ROWS = 5;
    localparam int KECCAK_COLS = 5;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } loader_state_e;

endpackage : keccak_dom_pkg

// File: rtl/keccak_lane_masker.sv
// Registered masking cell for one lane: splits the lane into XOR shares on load.
// Share0 and share1 live in separate registers and are never recombined here.
module keccak_lane_masker
    import keccak_dom_pkg::*;
#(
    parameter int WIDTH = KECCAK_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] lane_i,
    input  logic [WIDTH-1:0] rand_i,
    input  logic             load_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] share0_o,
    output logic [WIDTH-1:0] share1_o
);

    logic [WIDTH-1:0] share0_q;
    logic [WIDTH-1:0] share0_d;
    logic [WIDTH-1:0] share1_q;
    logic [WIDTH-1:0] share1_d;

    // Clear wins so a consumed row never leaves shares behind.
    always_comb begin
        share0_d = share0_q;
        share1_d = share1_q;
        if (clear_i) begin
            share0_d = '0;
            share1_d = '0;
        end else if (load_i) begin
            share0_d = lane_i ^ rand_i;
            share1_d = rand_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            share0_q <= '0;
            share1_q <= '0;
        end else begin
            share0_q <= share0_d;
            share1_q <= share1_d;
        end
    end

    assign share0_o = share0_q;
    assign share1_o = share1_q;

endmodule : keccak_lane_masker

// File: rtl/keccak_mask_loader.sv
// Front end of the DOM chi datapath: masks five incoming lanes into one
// two-share row and hands it to the S-box with a valid/ready handshake.
module keccak_mask_loader
    import keccak_dom_pkg::*;
#(
    parameter int WIDTH = KECCAK_W,
    parameter int ROWS  = KECCAK_ROWS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] lane_i,
    input  logic             lane_valid_i,
    output logic             lane_ready_o,
    input  logic [WIDTH-1:0] rand_i,
    output logic [WIDTH-1:0] A0_o,
    output logic [WIDTH-1:0] A1_o,
    output logic [WIDTH-1:0] B0_o,
    output logic [WIDTH-1:0] B1_o,
    output logic [WIDTH-1:0] C0_o,
    output logic [WIDTH-1:0] C1_o,
    output logic [WIDTH-1:0] D0_o,
    output logic [WIDTH-1:0] D1_o,
    output logic [WIDTH-1:0] E0_o,
    output logic [WIDTH-1:0] E1_o,
    output logic             row_valid_o,
    input  logic             row_ready_i,
    output logic [2:0]       row_idx_o,
    output logic             last_o
);

    // Both streams use valid/ready: a transfer happens on the rising edge where
    // valid and ready are both high; valid holds until then, ready may toggle freely.

    localparam logic [2:0] LAST_COL = 3'(KECCAK_COLS - 1);
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    loader_state_e state_q;
    loader_state_e state_d;
    logic [2:0]    col_cnt_q;
    logic [2:0]    col_cnt_d;
    logic [2:0]    row_idx_q;
    logic [2:0]    row_idx_d;
    logic          lane_ready_q;
    logic          lane_ready_d;
    logic          row_valid_q;
    logic          row_valid_d;
    logic          last_q;
    logic          last_d;

    logic                   lane_fire;
    logic                   row_fire;
    logic [KECCAK_COLS-1:0] load_en;
    logic [WIDTH-1:0]       share0 [KECCAK_COLS];
    logic [WIDTH-1:0]       share1 [KECCAK_COLS];

    assign lane_fire = lane_valid_i & lane_ready_q;
    assign row_fire  = row_valid_q & row_ready_i;

    // Handshake outputs are derived from the next state so they are registered.
    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        row_idx_d = row_idx_q;
        case (state_q)
            LOAD: begin
                if (lane_fire) begin
                    if (col_cnt_q == LAST_COL) begin
                        col_cnt_d = '0;
                        state_d   = EMIT;
                    end else begin
                        col_cnt_d = col_cnt_q + 3'd1;
                    end
                end
            end
            EMIT: begin
                if (row_fire) begin
                    state_d   = LOAD;
                    row_idx_d = (row_idx_q == LAST_ROW) ? 3'd0 : row_idx_q + 3'd1;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
        lane_ready_d = (state_d == LOAD);
        row_valid_d  = (state_d == EMIT);
        last_d       = row_valid_d && (row_idx_d == LAST_ROW);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= LOAD;
            col_cnt_q    <= '0;
            row_idx_q    <= '0;
            lane_ready_q <= 1'b0;
            row_valid_q  <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            row_idx_q    <= row_idx_d;
            lane_ready_q <= lane_ready_d;
            row_valid_q  <= row_valid_d;
            last_q       <= last_d;
        end
    end

    for (genvar c = 0; c < KECCAK_COLS; c++) begin : g_col
        assign load_en[c] = lane_fire && (col_cnt_q == 3'(c));

        keccak_lane_masker #(
            .WIDTH (WIDTH)
        ) u_masker (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .lane_i   (lane_i),
            .rand_i   (rand_i),
            .load_i   (load_en[c]),
            .clear_i  (row_fire),
            .share0_o (share0[c]),
            .share1_o (share1[c])
        );
    end

    assign A0_o = share0[0];
    assign A1_o = share1[0];
    assign B0_o = share0[1];
    assign B1_o = share1[1];
    assign C0_o = share0[2];
    assign C1_o = share1[2];
    assign D0_o = share0[3];
    assign D1_o = share1[3];
    assign E0_o = share0[4];
    assign E1_o = share1[4];

    assign lane_ready_o = lane_ready_q;
    assign row_valid_o  = row_valid_q;
    assign row_idx_o    = row_idx_q;
    assign last_o       = last_q;

endmodule : keccak_mask_loader

// File: doc/keccak_mask_loader.md
# keccak_mask_loader

Producer-side front end for the two-share DOM Keccak-f[800] χ datapath (`keccak_sbox`). It accepts plain 32-bit state lanes over a valid/ready stream and splits each lane into two Boolean shares using fresh randomness. It assembles five masked lanes (A..E) into one row and presents that row to the S-box stage with its own valid/ready handshake. It also tracks the row index across the 25-lane state and flags the last row.

## Interface
Parameters:
- `WIDTH`, 32, lane width in bits.
- `ROWS`, 5, rows per state. Row index wraps at `ROWS`.

Ports (one clock `clk_i`; reset `rst_i` is synchronous and active-high):
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  synchronous active-high reset.
- `lane_i`  in  WIDTH  unmasked input lane.
- `lane_valid_i`  in  1  `lane_i` is valid.
- `lane_ready_o`  out  1  loader can accept a lane this cycle.
- `rand_i`  in  WIDTH  fresh randomness. Consumed on each lane handshake.
- `A0_o`, `A1_o` … `E0_o`, `E1_o`  out  WIDTH each  registered share 0 and share 1 of row lanes A..E.
- `row_valid_o`  out  1  a complete masked row is presented.
- `row_ready_i`  in  1  downstream accepts the row.
- `row_idx_o`  out  3  index of the presented row, 0..`ROWS`-1.
- `last_o`  out  1  presented row is row `ROWS`-1.

## Operation
- The FSM has two states, LOAD and EMIT. Reset state is LOAD.
- LOAD behaviour:
  - `lane_ready_o` = 1.
  - On a lane handshake (`lane_valid_i & lane_ready_o`), slot `col_cnt` (0=A … 4=E) captures share0 = `lane_i ^ rand_i` and share1 = `rand_i`.
  - `col_cnt` then increments.
  - On the handshake with `col_cnt`=4, `col_cnt` returns to 0 and the FSM moves to EMIT.
- EMIT behaviour:
  - `row_valid_o` = 1 and `lane_ready_o` = 0. `lane_valid_i` is ignored and `rand_i` is not consumed.
  - Row registers, `row_idx_o` and `last_o` are held stable until the handshake.
  - On `row_valid_o & row_ready_i`, all ten share registers clear to 0, so no stale shares linger. The FSM returns to LOAD.
  - On that same handshake, `row_idx` increments and wraps from `ROWS`-1 to 0.
- `last_o` = `row_valid_o & (row_idx == ROWS-1)`.
- Masking rules:
  - Shares are XOR shares; unmasked lane = share0 ^ share1.
  - `lane_i` never reaches an output without passing through a register.
  - No register or output ever holds share0 and share1 of the same lane combined.
  - `rand_i` is never reused across two lanes.
- Arithmetic:
  - `col_cnt` is 3 bits, range 0..4.
  - `row_idx` is 3 bits, range 0..`ROWS`-1.
  - No other arithmetic; the datapath is XOR only.

## Timing
- Reset values: `lane_ready_o`=0 while `rst_i`=1, then 1 in the cycle after reset releases (LOAD). `row_valid_o`=0, `last_o`=0, `row_idx_o`=0, all share outputs = 0, internal `col_cnt`=0.
- Latency: `row_valid_o` rises in the cycle after the 5th lane handshake.
- Row throughput: best case is 6 cycles per row (5 LOAD plus 1 EMIT with `row_ready_i`=1). A full state takes 30 cycles.
- Backpressure: `row_valid_o` stays high for any number of cycles until `row_ready_i`. Outputs are unchanged while it waits.
- `lane_valid_i` may drop between lanes. Partial rows are held indefinitely with `col_cnt` preserved.
- Reset mid-row or mid-EMIT: the partial row is discarded, all registers return to their reset values, and the next accepted lane goes to slot A of row 0.
- `row_ready_i` asserted in LOAD has no effect.

## Structure
- Shared package `keccak_dom_pkg` holds:
  - constants `KECCAK_W`=32, `KECCAK_ROWS`=5, `KECCAK_COLS`=5;
  - the loader state enum `{LOAD, EMIT}`;
  - the same constants for reuse by the S-box and the later unmask stage.
- One sub-module, `keccak_lane_masker`: one lane's share pair as a registered masking cell. Inputs are lane, rand, load enable and clear; outputs are share0 and share1. It is instantiated five times.
- The FSM, counters and handshake logic live in the top module.

## Test plan
- **Single row:** lanes 0x1,0x2,0x3,0x4,0x5 with rand 0xA5A5A5A5, 0x0F0F0F0F, 0xFFFFFFFF, 0x0, 0x12345678 and `row_ready_i`=1.
  - Expected: `row_valid_o` one cycle after the 5th accept, `A1_o`=0xA5A5A5A5, `A0_o`=0xA5A5A5A4, `D0_o`=0x4, `row_idx_o`=0.
  - Expected: all shares are 0 in the cycle after the handshake.
- **Backpressure:** hold `row_ready_i`=0 for 7 cycles in EMIT.
  - Expected: outputs stable, `lane_ready_o`=0, and lanes and `rand_i` changes on the input are ignored.
- **Full state:** 25 lanes with random rand.
  - Expected: `row_idx_o` steps 0..4, `last_o`=1 only on row 4, and the next row is index 0 again.
  - Expected: share0 ^ share1 equals the input lane for every slot.
- **Gappy input:** deassert `lane_valid_i` for 3 cycles after lane 2.
  - Expected: lane 3 lands in slot D with no duplication or skip.
- **Reset mid-row:** assert `rst_i` after 3 lanes, then send 5 lanes.
  - Expected: the row contains only the post-reset lanes and `row_idx_o`=0.
- **Randomness independence:** the same lane 0xDEADBEEF is sent with rand_i values 0x0 and 0xFFFFFFFF.
  - Expected: share0 is 0xDEADBEEF and 0x21524110 respectively, and share1 equals rand_i in each case.
